// File: rtl/sensor_crc_frame_parser_pkg.sv
// Shared FSM state type, default CRC-8 constants and width helper for the sensor frame parsers.
package sensor_frame_pkg;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC} state_t;

    localparam logic [7:0] SHT_CRC_POLY = 8'h31;
    localparam logic [7:0] SHT_CRC_INIT = 8'hFF;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sensor_crc_frame_parser_if.sv
// Byte-stream in / verified-word out bundle; crc_err_count exists only when SHT_CRC_ERR_CNT_EN is defined.
interface sensor_crc_frame_parser_if
    import sensor_frame_pkg::*;
#(
    parameter int NUM_WORDS  = 2,
    parameter int WORD_BYTES = 2
);
    localparam int IDX_W = idx_width(NUM_WORDS);
    localparam int WW    = 8 * WORD_BYTES;

    logic                      frame_start;
    logic                      byte_valid;
    logic [7:0]                byte_data;
    logic                      word_valid;
    logic [WW-1:0]             word_data;
    logic [IDX_W-1:0]          word_index;
    logic [WW*NUM_WORDS-1:0]   words_out;
    logic [NUM_WORDS-1:0]      words_mask;
    logic                      crc_error;
    logic                      frame_done;
    logic                      frame_ok;
    logic                      busy;
`ifdef SHT_CRC_ERR_CNT_EN
    logic [15:0]               crc_err_count;
`endif

    modport master (
`ifdef SHT_CRC_ERR_CNT_EN
        input  crc_err_count,
`endif
        output frame_start, byte_valid, byte_data,
        input  word_valid, word_data, word_index, words_out, words_mask,
               crc_error, frame_done, frame_ok, busy
    );

    modport slave (
`ifdef SHT_CRC_ERR_CNT_EN
        output crc_err_count,
`endif
        input  frame_start, byte_valid, byte_data,
        output word_valid, word_data, word_index, words_out, words_mask,
               crc_error, frame_done, frame_ok, busy
    );

endinterface

// File: rtl/sensor_crc_frame_parser_crc8_byte.sv
// Single-cycle CRC-8 byte update, MSB-first, no reflection; latency 0 (combinational), no backpressure.
module crc8_byte
    import sensor_frame_pkg::*;
#(
    parameter logic [7:0] POLY = SHT_CRC_POLY
) (
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[7] ? ((crc_out << 1) ^ POLY) : (crc_out << 1);
        end
    end

endmodule

// File: rtl/sensor_crc_frame_parser.sv
// Frame parser: NUM_WORDS words of WORD_BYTES bytes, each followed by a CRC-8 byte; SHT_CRC_ERR_CNT_EN adds crc_err_count.
// Latency: results 1 clk after the CRC byte; no backpressure, one byte per clk accepted at full rate.
module sensor_crc_frame_parser
    import sensor_frame_pkg::*;
#(
    parameter int         NUM_WORDS  = 2,
    parameter int         WORD_BYTES = 2,
    parameter logic [7:0] CRC_POLY   = SHT_CRC_POLY,
    parameter logic [7:0] CRC_INIT   = SHT_CRC_INIT
) (
    input  logic                     clk,
    input  logic                     rst,
    sensor_crc_frame_parser_if.slave bus
);
    localparam int IDX_W = idx_width(NUM_WORDS);
    localparam int WW    = 8 * WORD_BYTES;
    localparam int BC_W  = idx_width(WORD_BYTES);

    state_t                    state, state_n;
    logic [IDX_W-1:0]          word_cnt, word_cnt_n, word_index, word_index_n;
    logic [BC_W-1:0]           byte_cnt, byte_cnt_n;
    logic [7:0]                crc, crc_n, crc_step;
    logic [WW-1:0]             shreg, shreg_n, word_data, word_data_n;
    logic [WW*NUM_WORDS-1:0]   words_out, words_out_n;
    logic [NUM_WORDS-1:0]      words_mask, words_mask_n;
    logic                      word_valid, word_valid_n;
    logic                      crc_error, crc_error_n;
    logic                      frame_done, frame_done_n;
    logic                      frame_ok, frame_ok_n;

    crc8_byte #(.POLY(CRC_POLY)) u_crc (
        .crc_in  (crc),
        .data    (bus.byte_data),
        .crc_out (crc_step)
    );

    always_comb begin
        state_n      = state;
        word_cnt_n   = word_cnt;
        byte_cnt_n   = byte_cnt;
        crc_n        = crc;
        shreg_n      = shreg;
        word_data_n  = word_data;
        word_index_n = word_index;
        words_out_n  = words_out;
        words_mask_n = words_mask;
        frame_ok_n   = frame_ok;
        word_valid_n = 1'b0;
        crc_error_n  = 1'b0;
        frame_done_n = 1'b0;

        // frame_start overrides everything, including a byte arriving in the same cycle
        if (bus.frame_start) begin
            state_n      = S_DATA;
            word_cnt_n   = '0;
            byte_cnt_n   = '0;
            crc_n        = CRC_INIT;
            words_mask_n = '0;
        end else begin
            case (state)
                S_DATA: if (bus.byte_valid) begin
                    shreg_n       = shreg << 8;
                    shreg_n[7:0]  = bus.byte_data;
                    crc_n         = crc_step;
                    byte_cnt_n    = byte_cnt + BC_W'(1);
                    if (byte_cnt == BC_W'(WORD_BYTES - 1))
                        state_n = S_CRC;
                end
                S_CRC: if (bus.byte_valid) begin
                    if (bus.byte_data == crc) begin
                        word_valid_n                         = 1'b1;
                        word_data_n                          = shreg;
                        word_index_n                         = word_cnt;
                        words_out_n[int'(word_cnt)*WW +: WW] = shreg;
                        words_mask_n[word_cnt]               = 1'b1;
                        if (word_cnt == IDX_W'(NUM_WORDS - 1)) begin
                            frame_done_n = 1'b1;
                            frame_ok_n   = 1'b1;
                            state_n      = S_IDLE;
                        end else begin
                            word_cnt_n = word_cnt + IDX_W'(1);
                            byte_cnt_n = '0;
                            crc_n      = CRC_INIT;
                            state_n    = S_DATA;
                        end
                    end else begin
                        crc_error_n  = 1'b1;
                        frame_done_n = 1'b1;
                        frame_ok_n   = 1'b0;
                        state_n      = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            crc        <= CRC_INIT;
            shreg      <= '0;
            word_data  <= '0;
            word_index <= '0;
            words_out  <= '0;
            words_mask <= '0;
            word_valid <= 1'b0;
            crc_error  <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
        end else begin
            state      <= state_n;
            word_cnt   <= word_cnt_n;
            byte_cnt   <= byte_cnt_n;
            crc        <= crc_n;
            shreg      <= shreg_n;
            word_data  <= word_data_n;
            word_index <= word_index_n;
            words_out  <= words_out_n;
            words_mask <= words_mask_n;
            word_valid <= word_valid_n;
            crc_error  <= crc_error_n;
            frame_done <= frame_done_n;
            frame_ok   <= frame_ok_n;
        end
    end

`ifdef SHT_CRC_ERR_CNT_EN
    logic [15:0] err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (crc_error_n && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end

    assign bus.crc_err_count = err_cnt;
`endif

    assign bus.word_valid = word_valid;
    assign bus.word_data  = word_data;
    assign bus.word_index = word_index;
    assign bus.words_out  = words_out;
    assign bus.words_mask = words_mask;
    assign bus.crc_error  = crc_error;
    assign bus.frame_done = frame_done;
    assign bus.frame_ok   = frame_ok;
    assign bus.busy       = (state != S_IDLE);

endmodule

// File: doc/sensor_crc_frame_parser.md
Name: sensor_crc_frame_parser

Overview:
Parametrised successor to the fixed two-word temperature/humidity parser. Consumes the byte stream from the I2C master, one byte per byte_valid strobe. Assembles NUM_WORDS words of WORD_BYTES bytes each; every word is followed by one CRC-8 byte. The CRC for each byte is computed in a single cycle, so no serial shift loop is needed. Publishes each verified word and a per-frame summary to downstream logic.

Parameters:
NUM_WORDS, 2, words per frame (>=1)
WORD_BYTES, 2, data bytes per word before its CRC byte (>=1)
CRC_POLY, 8'h31, CRC-8 polynomial, MSB-first, no reflection, no final XOR
CRC_INIT, 8'hFF, CRC register seed, reloaded at the start of every word
IDX_W, derived: max(1, clog2(NUM_WORDS)), word index width

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
frame_start  in  1  single-cycle pulse; begins a new frame and discards any partial frame
byte_valid  in  1  byte_data is valid this cycle
byte_data  in  8  received byte
word_valid  out  1  one-cycle pulse; word_data/word_index valid
word_data  out  8*WORD_BYTES  verified word; first received byte is the MSB
word_index  out  IDX_W  word position in the frame, 0-based
words_out  out  8*WORD_BYTES*NUM_WORDS  all verified words, word 0 in the LSB slice
words_mask  out  NUM_WORDS  bit i set once word i of the current frame is verified
crc_error  out  1  one-cycle pulse on a CRC mismatch
frame_done  out  1  one-cycle pulse when a frame ends, on success or abort
frame_ok  out  1  qualifies frame_done: 1 = all words passed
busy  out  1  FSM not in S_IDLE

Behaviour:
- Reset: all outputs 0; FSM in S_IDLE; counters 0; CRC register = CRC_INIT.
- FSM states:
  - S_IDLE: ignores byte_valid. frame_start -> S_DATA, clears words_mask, word_cnt=0, byte_cnt=0, crc=CRC_INIT.
  - S_DATA: on each byte_valid:
    - shift byte into the word shift register;
    - crc <= crc8_step(crc, byte);
    - byte_cnt++.
    - After the WORD_BYTES-th byte -> S_CRC.
  - S_CRC: on byte_valid, compare byte_data with crc.
    - Match:
      - registered next cycle: word_valid=1, word_data, word_index=word_cnt;
      - words_out slice and words_mask bit updated in the same cycle;
      - if word_cnt==NUM_WORDS-1: frame_done=1, frame_ok=1 -> S_IDLE;
      - else word_cnt++, byte_cnt=0, crc=CRC_INIT -> S_DATA.
    - Mismatch:
      - next cycle: crc_error=1, frame_done=1, frame_ok=0;
      - word not published; -> S_IDLE (frame aborted).
- Latency: outputs appear exactly 1 clk after the accepted CRC byte.
- Byte rate: back-to-back byte_valid is supported at full clock rate.
- frame_ok holds its value until the next frame_done. All other pulses last exactly one cycle.
- frame_start in any non-idle state: restart immediately. No frame_done for the discarded frame.
- frame_start and byte_valid in the same cycle: frame_start wins; the byte is dropped.
- words_out slices persist across frames until overwritten; words_mask indicates freshness.
- rst asserted mid-frame: immediate return to reset values; no pulses emitted.

Optional Feature:
Macro: SHT_CRC_ERR_CNT_EN
- Defined: adds output port crc_err_count [15:0].
  - Increments on every crc_error pulse.
  - Saturates at 16'hFFFF.
  - Cleared only by rst.
- Undefined: the port and the counter logic do not exist; all other behaviour is identical.

Decomposition:
- Package sensor_frame_pkg holds:
  - the state enum (S_IDLE, S_DATA, S_CRC);
  - default constants SHT_CRC_POLY=8'h31 and SHT_CRC_INIT=8'hFF.
- Sub-module crc8_byte: combinational; ports crc_in[7:0], data[7:0], crc_out[7:0]; parameter POLY.
  - Computes an 8-step unrolled MSB-first update starting from crc_in^data.
  - Reusable by the future SGP/SCD parsers.

Test Plan:
- Defaults; frame_start, then bytes BE EF 92 00 00 81:
  - word_valid with index0 data 16'hBEEF, then index1 data 16'h0000;
  - frame_done=1 and frame_ok=1 coincident with the second word_valid;
  - words_mask=2'b11; words_out=32'h0000_BEEF.
- Same frame but with a bad first CRC byte (BE EF 93 ...):
  - crc_error and frame_done with frame_ok=0, 1 clk after 93;
  - no word_valid; remaining bytes ignored; busy=0.
- Start frame BE EF, then frame_start, then 00 00 81 BE EF 92:
  - only the restarted frame is reported: index0=16'h0000, index1=16'hBEEF, frame_ok=1.
- frame_start and byte_valid(BE) in the same cycle:
  - BE is dropped; the next bytes EF ... lead to a CRC mismatch, as specified.
- NUM_WORDS=3, WORD_BYTES=1; bytes 00 AC, 00 AC, 00 AC:
  - three word_valid pulses, index 0,1,2, data 8'h00;
  - frame_ok=1;
  - AC is the expected CRC from crc8_byte and is cross-checked against the reference model.
- With SHT_CRC_ERR_CNT_EN: 3 aborted frames -> crc_err_count=3. Assert rst mid-frame -> all outputs and the count return to 0.
